// File: rtl/mlab_stream_reader_if.sv
// Bus between mlab_stream_reader and its surroundings: block command/status,
// MLAB read port and the output word stream.
interface mlab_stream_reader_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned AW    = 8
);
  logic                    start;
  logic [AW-1:0]           base_addr;
  logic [AW-1:0]           count;
  logic [AW-1:0]           readaddr;
  logic signed [WIDTH-1:0] ram_q;
  logic signed [WIDTH-1:0] out_data;
  logic                    out_valid;
  logic                    out_ready;
  logic                    busy;
  logic                    done;
  logic                    err;

  modport slave (
    input  start, base_addr, count, ram_q, out_ready,
    output readaddr, out_data, out_valid, busy, done, err
  );

  modport master (
    output start, base_addr, count, ram_q, out_ready,
    input  readaddr, out_data, out_valid, busy, done, err
  );
endinterface

// File: rtl/mlab_stream_reader.sv
// Streams a block of words out of an MLAB buffer (registered-output RAM, 1-cycle
// read latency) into a valid/ready stream, with a small skid buffer for stalls.
module mlab_stream_reader #(
  parameter int unsigned DEPTH = 20,
  parameter int unsigned WIDTH = 32,
  parameter int unsigned AW    = 8
) (
  input  logic                  i_clock,
  input  logic                  i_reset_n,
  mlab_stream_reader_if.slave   bus
);

  localparam int unsigned   BUF_DEPTH = 4;
  localparam logic [AW-1:0] DEPTH_AW  = AW'(DEPTH);
  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  typedef enum logic [1:0] {StIdle, StRead, StDrain} state_e;

  state_e                  r_state;
  logic [AW-1:0]           r_readaddr;
  logic [AW-1:0]           r_issue_left;
  logic [AW-1:0]           r_xfer_left;
  logic                    r_rd_v1;
  logic                    r_rd_v2;
  logic [2:0]              r_credit;
  logic signed [WIDTH-1:0] r_buf [BUF_DEPTH];
  logic [1:0]              r_wptr;
  logic [1:0]              r_rptr;
  logic [2:0]              r_cnt;
  logic                    r_busy;
  logic                    r_done;
  logic                    r_err;

  logic          w_pop;
  logic          w_push;
  logic          w_start_ok;
  logic          w_accept;
  logic          w_reject;
  logic          w_issue_more;
  logic          w_issue;
  logic [AW-1:0] w_next_addr;

  assign w_pop        = (r_cnt != 3'd0) && bus.out_ready;
  // r_rd_v2 marks the cycle in which ram_q carries the word read two edges ago.
  assign w_push       = r_rd_v2;
  assign w_start_ok   = (bus.count != '0) && (bus.count <= DEPTH_AW) &&
                        (bus.base_addr < DEPTH_AW);
  assign w_accept     = (r_state == StIdle) && bus.start && w_start_ok;
  assign w_reject     = (r_state == StIdle) && bus.start && !w_start_ok;
  // Credit counts buffered words plus reads in flight, so the buffer never overflows.
  assign w_issue_more = (r_state == StRead) && (r_issue_left != '0) &&
                        (r_credit < 3'(BUF_DEPTH));
  assign w_issue      = w_accept || w_issue_more;
  assign w_next_addr  = (r_readaddr == LAST_ADDR) ? '0 : r_readaddr + 1'b1;

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state      <= StIdle;
      r_readaddr   <= '0;
      r_issue_left <= '0;
      r_xfer_left  <= '0;
      r_rd_v1      <= 1'b0;
      r_rd_v2      <= 1'b0;
      r_credit     <= '0;
      r_wptr       <= '0;
      r_rptr       <= '0;
      r_cnt        <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
      for (int unsigned i = 0; i < BUF_DEPTH; i++) begin
        r_buf[i] <= '0;
      end
    end else begin
      r_done   <= 1'b0;
      r_err    <= w_reject;
      r_rd_v1  <= w_issue;
      r_rd_v2  <= r_rd_v1;
      r_credit <= r_credit + {2'b00, w_issue} - {2'b00, w_pop};
      r_cnt    <= r_cnt + {2'b00, w_push} - {2'b00, w_pop};

      if (w_push) begin
        r_buf[r_wptr] <= bus.ram_q;
        r_wptr        <= r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end

      case (r_state)
        StIdle: begin
          if (w_accept) begin
            r_state      <= StRead;
            r_busy       <= 1'b1;
            r_readaddr   <= bus.base_addr;
            r_issue_left <= bus.count - 1'b1;
            r_xfer_left  <= bus.count;
          end
        end
        StRead: begin
          if (w_issue_more) begin
            r_readaddr   <= w_next_addr;
            r_issue_left <= r_issue_left - 1'b1;
          end
          if ((r_issue_left == '0) || (w_issue_more && (r_issue_left == AW'(1)))) begin
            r_state <= StDrain;
          end
        end
        StDrain: ;
        default: r_state <= StIdle;
      endcase

      // Final transfer always lands in DRAIN; checked for any busy state for robustness.
      if ((r_state != StIdle) && w_pop) begin
        r_xfer_left <= r_xfer_left - 1'b1;
        if (r_xfer_left == AW'(1)) begin
          r_state <= StIdle;
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
        end
      end
    end
  end

  assign bus.readaddr  = r_readaddr;
  assign bus.out_data  = r_buf[r_rptr];
  assign bus.out_valid = (r_cnt != 3'd0);
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.err       = r_err;

endmodule

// File: tb/tb_mlab_stream_reader.sv
// Randomized scoreboard bench for mlab_stream_reader with a registered-output RAM
// model, plus directed scenarios for latency, wrap, stalls, rejects and reset.
module tb_mlab_stream_reader;

  localparam int unsigned DEPTH = 20;
  localparam int unsigned WIDTH = 32;
  localparam int unsigned AW    = 8;

  typedef struct {
    logic signed [WIDTH-1:0] data;
    bit                      last;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mlab_stream_reader_if #(.WIDTH(WIDTH), .AW(AW)) bus_if ();

  mlab_stream_reader #(.DEPTH(DEPTH), .WIDTH(WIDTH), .AW(AW)) dut (
    .i_clock   (clk),
    .i_reset_n (rst_n),
    .bus       (bus_if)
  );

  logic signed [WIDTH-1:0] mem [DEPTH];
  exp_t                    sb[$];
  bit                      model_active = 1'b0;
  bit                      exp_done     = 1'b0;
  bit                      prev_stall   = 1'b0;
  logic signed [WIDTH-1:0] prev_data;
  int                      n_checks = 0;
  int                      n_pass   = 0;
  int                      n_xfer   = 0;
  int                      ready_mode  = 0;
  int                      ready_phase = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Registered-output buffer: data for readaddr appears one edge later.
  always @(posedge clk) begin
    bus_if.ram_q <= (bus_if.readaddr < AW'(DEPTH)) ? mem[bus_if.readaddr] : '0;
  end

  always @(posedge clk) begin
    #1;
    ready_phase = (ready_phase + 1) % 3;
    case (ready_mode)
      0:       bus_if.out_ready = 1'b1;
      1:       bus_if.out_ready = (ready_phase == 0);
      default: bus_if.out_ready = ($urandom_range(0, 1) == 1);
    endcase
  end

  // Monitor: samples mid-cycle, before the edge at which a transfer takes place.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (bus_if.done || exp_done) chk("done_pulse", bus_if.done, exp_done);
      if (bus_if.done) chk("busy_low_at_done", bus_if.busy, 0);
      if (prev_stall) begin
        chk("stall_valid", bus_if.out_valid, 1);
        chk("stall_data", bus_if.out_data, prev_data);
      end
      if (bus_if.busy) chk("addr_range", bus_if.readaddr < AW'(DEPTH), 1);
      exp_done = 1'b0;
      if (bus_if.out_valid && bus_if.out_ready) begin
        n_xfer++;
        chk("word_expected", sb.size() != 0, 1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk("data", bus_if.out_data, e.data);
          if (e.last) begin
            model_active = 1'b0;
            exp_done     = 1'b1;
          end
        end
      end
      prev_stall = bus_if.out_valid && !bus_if.out_ready;
      prev_data  = bus_if.out_data;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input int b, input int c);
    bit            ok;
    bit            was_active;
    logic [AW-1:0] addr_before;
    ok          = (c >= 1) && (c <= DEPTH) && (b >= 0) && (b < DEPTH);
    was_active  = model_active;
    addr_before = bus_if.readaddr;
    bus_if.start     = 1'b1;
    bus_if.base_addr = AW'(b);
    bus_if.count     = AW'(c);
    if (ok && !was_active) begin
      for (int k = 0; k < c; k++) begin
        sb.push_back('{data: mem[(b + k) % DEPTH], last: (k == c - 1)});
      end
      model_active = 1'b1;
    end
    tick();
    bus_if.start = 1'b0;
    if (was_active) begin
      chk("start_while_busy_no_err", bus_if.err, 0);
    end else if (!ok) begin
      chk("reject_err", bus_if.err, 1);
      chk("reject_busy", bus_if.busy, 0);
      chk("reject_addr_hold", bus_if.readaddr, addr_before);
    end else begin
      chk("accept_no_err", bus_if.err, 0);
      chk("accept_busy", bus_if.busy, 1);
      chk("accept_first_addr", bus_if.readaddr, b);
    end
  endtask

  task automatic wait_block_end();
    int cyc = 0;
    while (model_active && cyc < 2000) begin
      tick();
      cyc++;
    end
    chk("block_completes", model_active, 0);
    if (model_active) begin
      sb.delete();
      model_active = 1'b0;
    end
  endtask

  task automatic wait_idle();
    wait_block_end();
    tick();
    tick();
    chk("scoreboard_empty", sb.size(), 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_readaddr"}, bus_if.readaddr, 0);
    chk({tag, "_out_data"}, bus_if.out_data, 0);
    chk({tag, "_out_valid"}, bus_if.out_valid, 0);
    chk({tag, "_busy"}, bus_if.busy, 0);
    chk({tag, "_done"}, bus_if.done, 0);
    chk({tag, "_err"}, bus_if.err, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    int cyc;
    int b;
    int c;
    bus_if.start     = 1'b0;
    bus_if.base_addr = '0;
    bus_if.count     = '0;
    bus_if.out_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) mem[i] = WIDTH'(i * 3);

    #12;
    check_reset_outputs("reset");
    tick();
    rst_n = 1'b1;
    tick();

    // Latency and full-rate throughput.
    ready_mode = 0;
    tick();
    do_start(0, 4);
    chk("lat_e0_valid", bus_if.out_valid, 0);
    tick();
    chk("lat_e1_valid", bus_if.out_valid, 0);
    tick();
    chk("lat_e2_valid", bus_if.out_valid, 1);
    chk("lat_e2_data", bus_if.out_data, 0);
    for (int k = 1; k < 4; k++) begin
      tick();
      chk("rate_valid", bus_if.out_valid, 1);
      chk("rate_data", bus_if.out_data, 3 * k);
    end
    tick();
    chk("done_after_last", bus_if.done, 1);
    chk("busy_after_last", bus_if.busy, 0);
    wait_idle();

    // Address wrap.
    do_start(18, 5);
    for (int k = 1; k < 5; k++) begin
      tick();
      chk("wrap_addr", bus_if.readaddr, (18 + k) % DEPTH);
    end
    wait_idle();

    // Full-depth block under 1,0,0 backpressure.
    ready_mode = 1;
    do_start(7, 20);
    wait_idle();
    ready_mode = 0;

    // Rejected starts.
    do_start(0, 0);
    do_start(0, DEPTH + 1);
    do_start(DEPTH, 1);
    tick();
    chk("reject_no_busy", bus_if.busy, 0);

    // Ignored start while busy, then start in the done cycle.
    ready_mode = 2;
    do_start(3, 6);
    tick();
    tick();
    do_start(10, 3);
    wait_block_end();
    chk("done_cycle", bus_if.done, 1);
    do_start(12, 4);
    wait_idle();

    // Reset mid-block.
    ready_mode = 0;
    n0 = n_xfer;
    do_start(0, 8);
    cyc = 0;
    while (n_xfer < n0 + 2 && cyc < 100) begin
      tick();
      cyc++;
    end
    chk("two_words_before_reset", n_xfer >= n0 + 2, 1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    sb.delete();
    model_active = 1'b0;
    exp_done     = 1'b0;
    prev_stall   = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    n0 = n_xfer;
    do_start(5, 2);
    wait_idle();
    chk("post_reset_word_count", n_xfer - n0, 2);

    // Randomized blocks with random data and backpressure.
    for (int blk = 0; blk < 40; blk++) begin
      for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
      ready_mode = $urandom_range(0, 2);
      b = $urandom_range(0, DEPTH - 1);
      c = $urandom_range(1, DEPTH);
      if ($urandom_range(0, 7) == 0) begin
        case ($urandom_range(0, 2))
          0:       c = 0;
          1:       c = $urandom_range(DEPTH + 1, 255);
          default: b = $urandom_range(DEPTH, 255);
        endcase
      end
      do_start(b, c);
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(0, 4)) tick();
        do_start($urandom_range(0, DEPTH - 1), $urandom_range(1, DEPTH));
      end
      wait_idle();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mlab_stream_reader.md
MLAB_STREAM_READER -- requirements
Module: mlab_stream_reader

Interface
REQ-001 Parameter: DEPTH, 20, number of words in the attached MLAB buffer (addresses 0..DEPTH-1).
REQ-002 Parameter: WIDTH, 32, data word width.
REQ-003 Parameter: AW, 8, address width of readaddr, base_addr and count.
REQ-004 clock  input  1  single clock; all state updates on posedge clock.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 start  input  1  single-cycle request to stream a block out of the buffer.
REQ-007 base_addr  input  AW  first buffer address of the block; sampled only when start is accepted.
REQ-008 count  input  AW  number of words in the block, 1..DEPTH; sampled only when start is accepted.
REQ-009 readaddr  output  AW  registered read address driven to the MLAB buffer.
REQ-010 ram_q  input  WIDTH (signed)  buffer read data, valid one clock after readaddr is presented.
REQ-011 out_data  output  WIDTH (signed)  streamed word.
REQ-012 out_valid  output  1  out_data holds a valid word.
REQ-013 out_ready  input  1  downstream accepts the word; transfer occurs when out_valid and out_ready are both high at a clock edge.
REQ-014 busy  output  1  high from an accepted start until done.
REQ-015 done  output  1  one-cycle pulse after the final word transfers.
REQ-016 err  output  1  one-cycle pulse when a start is rejected.

Function
REQ-017 FSM states SHALL be IDLE, READ (issuing addresses) and DRAIN (all reads issued, output buffer emptying).
REQ-018 In IDLE, start SHALL be accepted when 1 <= count <= DEPTH and base_addr < DEPTH; next state READ, busy=1, readaddr=base_addr on the following cycle.
REQ-019 In IDLE, start with count=0, count>DEPTH or base_addr>=DEPTH SHALL pulse err for one cycle, perform no reads, and stay in IDLE.
REQ-020 start SHALL be ignored (no err, no effect) while busy=1.
REQ-021 Successive addresses SHALL be base_addr, base_addr+1, ..., wrapping from DEPTH-1 to 0 (modulo DEPTH, never above DEPTH-1).
REQ-022 Read latency SHALL be: readaddr driven after edge E0, ram_q valid after E1, word in out_data with out_valid=1 after E2.
REQ-023 An output buffer of at least 2 entries SHALL absorb the in-flight read, so no word is lost or duplicated under any out_ready pattern.
REQ-024 A new address SHALL be issued only if buffer occupancy plus in-flight reads < buffer depth; otherwise readaddr SHALL hold its value.
REQ-025 With out_ready held high, throughput SHALL be one word per clock after the initial 2-cycle latency.
REQ-026 out_data SHALL stay stable while out_valid=1 and out_ready=0.
REQ-027 Words SHALL be delivered in address order, exactly count words per block.
REQ-028 After the last address issues, FSM SHALL move READ->DRAIN; after the last transfer, DRAIN->IDLE with done=1 for one cycle and busy=0 in that same cycle.
REQ-029 A start arriving in the done cycle SHALL be accepted, since the FSM is in IDLE.
REQ-030 Only readaddr and ram_q couple to the buffer; the block SHALL never drive a write enable.

Reset
REQ-031 reset_n low SHALL immediately (asynchronously) force IDLE, readaddr=0, out_data=0, out_valid=0, busy=0, done=0, err=0, and empty the output buffer and in-flight tracking.
REQ-032 Reset asserted mid-block SHALL abandon the block; after release no stale word SHALL appear and the next start SHALL begin cleanly.

Verification
REQ-033 Buffer preloaded mem[i]=i*3; start, base=0, count=4, out_ready=1 -> out_data 0,3,6,9 on 4 consecutive cycles, first valid 2 cycles after start edge, done 1 cycle after 9 transfers.
REQ-034 base=18, count=5 -> readaddr sequence 18,19,0,1,2; out_data mem[18],mem[19],mem[0],mem[1],mem[2].
REQ-035 count=20, out_ready toggling 1,0,0,1,... -> all 20 words delivered in order, none dropped or repeated, out_data stable while stalled, readaddr never exceeds 19.
REQ-036 start with count=0, then count=21, then base=20 -> err pulse each time, no readaddr change, busy stays 0.
REQ-037 reset_n low after 2 of 8 words transfer -> outputs zero at once; after release start base=5, count=2 -> exactly mem[5],mem[6], then done.
REQ-038 start pulsed while busy, and again in the done cycle -> first ignored; second starts a new block with correct data.
